byte_lane_arbiter: RTL and testbench

- Shares one 8-to-32 byte packer between 4 byte-wide requester lanes.
- Grants one lane for a full 4-byte word, then moves on round-robin, so each 32-bit word at the packer output carries bytes from a single lane.
- Drives the packer's valid/8-bit data input and tags each byte with lane id and word-boundary flags.
- If the owning lane stalls too long mid-word, pads the word with 0x00 so the packer never hangs.

---
 rtl/byte_arb_pkg.sv | 27 ++
 rtl/rr_picker.sv | 27 ++
 rtl/byte_lane_arbiter.sv | 152 +++++++++++++++
 tb/tb_byte_lane_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_arb_pkg.sv
// rtl/byte_arb_pkg.sv - shared constants and state encoding for the byte lane arbiter
package byte_arb_pkg;

    localparam int NUM_LANES      = 4;
    localparam int LANE_W         = 2;
    localparam int DATA_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int TIMEOUT        = 8;
    localparam int BC_W           = $clog2(BYTES_PER_WORD);
    localparam int ST_W           = $clog2(TIMEOUT);

    localparam logic [DATA_W-1:0] PAD_BYTE    = 8'h00;
    localparam logic [BC_W-1:0]   LAST_BYTE   = BC_W'(BYTES_PER_WORD - 1);
    localparam logic [ST_W-1:0]   STALL_LIMIT = ST_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        PAD   = 2'd2
    } state_t;

    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
        lane_onehot       = '0;
        lane_onehot[lane] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - round-robin request picker starting the scan at rr_ptr
module rr_picker
    import byte_arb_pkg::*;
(
    input  logic [NUM_LANES-1:0] req,
    input  logic [LANE_W-1:0]    rr_ptr,
    output logic                 found,
    output logic [LANE_W-1:0]    lane
);

    logic [LANE_W-1:0] idx;

    // Scan from the farthest offset down so the lane nearest rr_ptr wins last.
    always_comb begin
        found = 1'b0;
        lane  = rr_ptr;
        idx   = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            idx = rr_ptr + LANE_W'(i);
            if (req[idx]) begin
                found = 1'b1;
                lane  = idx;
            end
        end
    end

endmodule

// File: rtl/byte_lane_arbiter.sv
// rtl/byte_lane_arbiter.sv - grants one lane per 4-byte word to a shared 8-to-32 packer
module byte_lane_arbiter
    import byte_arb_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_LANES-1:0]        req,
    input  logic [NUM_LANES*DATA_W-1:0] data_in,
    output logic [NUM_LANES-1:0]        ack,
    output logic                        valid_out,
    output logic [DATA_W-1:0]           data_out,
    output logic [LANE_W-1:0]           lane_out,
    output logic                        sof,
    output logic                        eow,
    output logic                        pad
);

    state_t            state, state_nxt;
    logic [LANE_W-1:0] rr_ptr;
    logic [LANE_W-1:0] owner;
    logic [BC_W-1:0]   byte_cnt;
    logic [ST_W-1:0]   stall_cnt;

    logic              pick_found;
    logic [LANE_W-1:0] pick_lane;

    logic              take;
    logic [DATA_W-1:0] take_byte;
    logic [LANE_W-1:0] take_lane;
    logic              take_sof;
    logic              take_eow;
    logic              take_pad;

    rr_picker u_rr_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .lane   (pick_lane)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_found) state_nxt = BURST;
            end
            BURST: begin
                if (req[owner]) begin
                    if (byte_cnt == LAST_BYTE) state_nxt = IDLE;
                end else if (stall_cnt == STALL_LIMIT) begin
                    state_nxt = PAD;
                end
            end
            PAD: begin
                if (byte_cnt == LAST_BYTE) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset gates the IDLE grant so ack drops together with the async clear.
    always_comb begin
        ack       = '0;
        take      = 1'b0;
        take_byte = PAD_BYTE;
        take_lane = '0;
        take_sof  = 1'b0;
        take_eow  = 1'b0;
        take_pad  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found && !reset) begin
                    ack       = lane_onehot(pick_lane);
                    take      = 1'b1;
                    take_byte = data_in[int'(pick_lane)*DATA_W +: DATA_W];
                    take_lane = pick_lane;
                    take_sof  = 1'b1;
                end
            end
            BURST: begin
                if (req[owner]) begin
                    ack       = lane_onehot(owner);
                    take      = 1'b1;
                    take_byte = data_in[int'(owner)*DATA_W +: DATA_W];
                    take_lane = owner;
                    take_eow  = (byte_cnt == LAST_BYTE);
                end
            end
            PAD: begin
                take      = 1'b1;
                take_lane = owner;
                take_pad  = 1'b1;
                take_eow  = (byte_cnt == LAST_BYTE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            owner     <= '0;
            byte_cnt  <= '0;
            stall_cnt <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            lane_out  <= '0;
            sof       <= 1'b0;
            eow       <= 1'b0;
            pad       <= 1'b0;
        end else begin
            valid_out <= take;
            data_out  <= take_byte;
            lane_out  <= take_lane;
            sof       <= take_sof;
            eow       <= take_eow;
            pad       <= take_pad;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner     <= pick_lane;
                        byte_cnt  <= BC_W'(1);
                        stall_cnt <= '0;
                    end
                end
                BURST: begin
                    if (req[owner]) begin
                        byte_cnt  <= byte_cnt + 1'b1;
                        stall_cnt <= '0;
                        if (byte_cnt == LAST_BYTE) rr_ptr <= owner + 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                PAD: begin
                    byte_cnt <= byte_cnt + 1'b1;
                    if (byte_cnt == LAST_BYTE) rr_ptr <= owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_lane_arbiter.sv
// tb/tb_byte_lane_arbiter.sv - directed self-checking bench for byte_lane_arbiter
module tb_byte_lane_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  ack;
    logic        valid_out;
    logic [7:0]  data_out;
    logic [1:0]  lane_out;
    logic        sof;
    logic        eow;
    logic        pad;

    int total;
    int bad;

    logic [3:0]  o_ack;
    logic [13:0] o_out;

    byte_lane_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data_in   (data_in),
        .ack       (ack),
        .valid_out (valid_out),
        .data_out  (data_out),
        .lane_out  (lane_out),
        .sof       (sof),
        .eow       (eow),
        .pad       (pad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] pk(input logic v, input logic s, input logic e,
                                       input logic p, input logic [1:0] l, input logic [7:0] d);
        return {v, s, e, p, l, d};
    endfunction

    // Registered outputs are sampled at the negedge (byte from the previous cycle),
    // ack is sampled 1ns after the new inputs settle (this cycle).
    task automatic step(input logic [3:0] r, input logic [31:0] d);
        @(negedge clk);
        o_out   = {valid_out, sof, eow, pad, lane_out, data_out};
        req     = r;
        data_in = d;
        #1;
        o_ack   = ack;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        req     = '0;
        data_in = '0;
        @(negedge clk);
        reset   = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        req     = 4'b1111;
        data_in = 32'hFFFF_FFFF;
        @(negedge clk);
        #1;
        total++;
        if (ack !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ack got %b want 0000", ack);
        end
        total++;
        if ({valid_out, sof, eow, pad, lane_out, data_out} !== 14'h0) begin
            bad++;
            $display("FAIL reset_outputs got %h want 0000", {valid_out, sof, eow, pad, lane_out, data_out});
        end
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        step(4'b0000, 32'h0);
        total++;
        if (o_ack !== 4'b0000 || o_out !== 14'h0) begin
            bad++;
            $display("FAIL reset_release got ack=%b out=%h want ack=0000 out=0000", o_ack, o_out);
        end
    endtask

    task automatic test_single_lane();
        logic [7:0]  b [4];
        logic [13:0] exp_out;
        logic [3:0]  exp_ack;
        b = '{8'hFF, 8'hDD, 8'h00, 8'h03};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) step(4'b0100, {8'h00, b[k], 16'h0000});
            else       step(4'b0000, 32'h0);
            exp_ack = (k < 4) ? 4'b0100 : 4'b0000;
            if (k == 0 || k == 5) exp_out = 14'h0;
            else                  exp_out = pk(1'b1, k == 1, k == 4, 1'b0, 2'd2, b[k-1]);
            total++;
            if (o_ack !== exp_ack) begin
                bad++;
                $display("FAIL single_ack step=%0d got %b want %b", k, o_ack, exp_ack);
            end
            total++;
            if (exp_out[13] ? (o_out !== exp_out) : (o_out[13] !== 1'b0)) begin
                bad++;
                $display("FAIL single_out step=%0d got %h want %h", k, o_out, exp_out);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [13:0] exp_out;
        logic [3:0]  exp_ack;
        logic [1:0]  ln;
        int          p;
        do_reset();
        for (int s = 0; s < 21; s++) begin
            if (s < 20) step(4'b1111, 32'h0302_0100);
            else        step(4'b0000, 32'h0);
            ln      = 2'((s / 4) % 4);
            exp_ack = (s < 20) ? (4'b0001 << ln) : 4'b0000;
            if (s == 0) begin
                exp_out = 14'h0;
            end else begin
                p       = s - 1;
                ln      = 2'((p / 4) % 4);
                exp_out = pk(1'b1, (p % 4) == 0, (p % 4) == 3, 1'b0, ln, {6'd0, ln});
            end
            total++;
            if (o_ack !== exp_ack) begin
                bad++;
                $display("FAIL rr_ack step=%0d got %b want %b", s, o_ack, exp_ack);
            end
            total++;
            if (exp_out[13] ? (o_out !== exp_out) : (o_out[13] !== 1'b0)) begin
                bad++;
                $display("FAIL rr_out step=%0d got %h want %h", s, o_out, exp_out);
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0]  rq  [9];
        logic [7:0]  by  [9];
        logic [3:0]  ea  [9];
        logic [13:0] eo  [9];
        rq = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        by = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h33, 8'h44, 8'h00, 8'h00};
        ea = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        eo = '{14'h0,
               pk(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'h11),
               pk(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'h22),
               14'h0, 14'h0, 14'h0,
               pk(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'h33),
               pk(1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 8'h44),
               14'h0};
        do_reset();
        for (int s = 0; s < 9; s++) begin
            step(rq[s], {16'h0000, by[s], 8'h00});
            total++;
            if (o_ack !== ea[s]) begin
                bad++;
                $display("FAIL stall_ack step=%0d got %b want %b", s, o_ack, ea[s]);
            end
            total++;
            if (eo[s][13] ? (o_out !== eo[s]) : (o_out[13] !== 1'b0)) begin
                bad++;
                $display("FAIL stall_out step=%0d got %h want %h", s, o_out, eo[s]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [3:0]  rq;
        logic [31:0] d;
        logic [3:0]  exp_ack;
        logic [13:0] exp_out;
        do_reset();
        for (int s = 0; s < 14; s++) begin
            if (s == 0)                rq = 4'b1000;
            else if (s >= 9 && s < 13) rq = 4'b1111;
            else                       rq = 4'b0000;
            d = (s == 0) ? 32'hAA00_0000 : 32'h0;
            step(rq, d);
            if (s == 0)       exp_ack = 4'b1000;
            else if (s == 12) exp_ack = 4'b0001;
            else              exp_ack = 4'b0000;
            if (s == 1)                   exp_out = pk(1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 8'hAA);
            else if (s >= 10 && s <= 12)  exp_out = pk(1'b1, 1'b0, s == 12, 1'b1, 2'd3, 8'h00);
            else if (s == 13)             exp_out = pk(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
            else                          exp_out = 14'h0;
            total++;
            if (o_ack !== exp_ack) begin
                bad++;
                $display("FAIL timeout_ack step=%0d got %b want %b", s, o_ack, exp_ack);
            end
            total++;
            if (exp_out[13] ? (o_out !== exp_out) : (o_out[13] !== 1'b0)) begin
                bad++;
                $display("FAIL timeout_out step=%0d got %h want %h", s, o_out, exp_out);
            end
        end
    endtask

    task automatic test_contention();
        logic [3:0]  rq [6];
        logic [31:0] dd [6];
        logic [3:0]  ea [6];
        logic [13:0] eo [6];
        rq = '{4'b0001, 4'b0111, 4'b0111, 4'b0111, 4'b0110, 4'b0110};
        dd = '{32'h0000_00A0, 32'h00C0_B0A1, 32'h00C0_B0A2, 32'h00C0_B0A3, 32'h00C0_B0A3, 32'h00C0_B0A3};
        ea = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
        eo = '{14'h0,
               pk(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'hA0),
               pk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'hA1),
               pk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'hA2),
               pk(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'hA3),
               pk(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'hB0)};
        do_reset();
        for (int s = 0; s < 6; s++) begin
            step(rq[s], dd[s]);
            total++;
            if (o_ack !== ea[s]) begin
                bad++;
                $display("FAIL contention_ack step=%0d got %b want %b", s, o_ack, ea[s]);
            end
            total++;
            if (eo[s][13] ? (o_out !== eo[s]) : (o_out[13] !== 1'b0)) begin
                bad++;
                $display("FAIL contention_out step=%0d got %h want %h", s, o_out, eo[s]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        step(4'b0001, 32'h0000_0050);
        step(4'b0001, 32'h0000_0051);
        total++;
        if (o_out !== pk(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h50)) begin
            bad++;
            $display("FAIL midrst_first got %h want %h", o_out, pk(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h50));
        end
        @(negedge clk);
        total++;
        if (valid_out !== 1'b1 || data_out !== 8'h51) begin
            bad++;
            $display("FAIL midrst_second got valid=%b data=%h want valid=1 data=51", valid_out, data_out);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({valid_out, sof, eow, pad} !== 4'b0000) begin
            bad++;
            $display("FAIL midrst_clear got %b want 0000", {valid_out, sof, eow, pad});
        end
        total++;
        if (ack !== 4'b0000) begin
            bad++;
            $display("FAIL midrst_ack got %b want 0000", ack);
        end
        @(negedge clk);
        reset   = 1'b0;
        req     = 4'b0001;
        data_in = 32'h0000_0052;
        #1;
        total++;
        if (ack !== 4'b0001) begin
            bad++;
            $display("FAIL midrst_regrant got %b want 0001", ack);
        end
        step(4'b0001, 32'h0000_0053);
        total++;
        if (o_out !== pk(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h52)) begin
            bad++;
            $display("FAIL midrst_fresh got %h want %h", o_out, pk(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h52));
        end
        step(4'b0000, 32'h0);
        total++;
        if (o_out !== pk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h53)) begin
            bad++;
            $display("FAIL midrst_next got %h want %h", o_out, pk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h53));
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        req     = '0;
        data_in = '0;
        test_reset();
        test_single_lane();
        test_round_robin();
        test_stall();
        test_timeout();
        test_contention();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
